// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one memory request in flight,
// and buffers returned {instruction, pc} pairs in front of the IF/ID register.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_load,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [31:0]     instr_mem [FIFO_DEPTH];
    logic [31:0]     pc_mem    [FIFO_DEPTH];

    logic            accept;
    logic            push;
    logic            pop;

    assign imem_req  = (state_q == S_FETCH) && (count_q < CW'(FIFO_DEPTH));
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;
    assign valid_out = (count_q != '0);

    // A redirect kills both the incoming word and any consumer pop on the same edge.
    assign push = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
    assign pop  = valid_out && id_load && !redirect_valid;

    assign instruction_out = valid_out ? instr_mem[rd_ptr_q] : NOP_INSTR;
    assign pc_out          = valid_out ? pc_mem[rd_ptr_q]    : 32'h0000_0000;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        case (state_q)
            S_FETCH: begin
                if (accept) begin
                    inflight_pc_d = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + 32'd4;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            S_FLUSH: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'd3;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            // Any request already on the bus must have its response swallowed.
            if ((state_q == S_FETCH && accept) ||
                (state_q == S_WAIT && !imem_rvalid)) begin
                state_d = S_FLUSH;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_FETCH;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= 32'h0000_0000;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Buffer storage carries no reset; valid_out masks stale entries.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clock) begin
            if (!reset && push && (wr_ptr_q == AW'(gi))) begin
                instr_mem[gi] <= imem_rdata;
                pc_mem[gi]    <= inflight_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a one-cycle memory responder plus a queue
// of expected {instruction, pc} entries that is checked against the buffer head.
module tb_instr_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] HI_RST = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_ready, imem_rvalid, id_load, redirect_valid;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, valid_out;
    logic [31:0] imem_addr, instruction_out, pc_out;
    logic        hi_req, hi_valid;
    logic [31:0] hi_addr, hi_instr, hi_pc_out;

    always #5 clock = ~clock;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) u_dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_load(id_load),
        .instruction_out(instruction_out), .pc_out(pc_out), .valid_out(valid_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Second instance with a high reset PC shares all inputs and runs in lockstep.
    instr_fetch_unit #(.RESET_PC(HI_RST), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) u_hi (
        .clock(clock), .reset(reset),
        .imem_req(hi_req), .imem_addr(hi_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_load(id_load),
        .instruction_out(hi_instr), .pc_out(hi_pc_out), .valid_out(hi_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      sb[$];
    bit          pending;
    bit          discard;
    logic [31:0] pending_addr;
    logic [31:0] model_pc;
    logic [31:0] hi_pc;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input logic [31:0] rst_pc, input logic [31:0] rst_hi);
        sb.delete();
        pending  = 1'b0;
        discard  = 1'b0;
        model_pc = rst_pc;
        hi_pc    = rst_hi;
    endtask

    // One clock: drive inputs at the falling edge, check, update the model, advance.
    task automatic step(input bit rdy, input bit ld, input bit rv_en, input bit redir,
                        input logic [31:0] rpc);
        bit     rv, acc, do_pop;
        entry_t e;
        rv             = pending && rv_en;
        imem_ready     = rdy;
        id_load        = ld;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(pending_addr) : 32'hDEAD_BEEF;
        #1;
        chk("req", {31'b0, imem_req}, {31'b0, !pending && (sb.size() < DEPTH)});
        chk("valid", {31'b0, valid_out}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) begin
            chk("instr", instruction_out, sb[0].instr);
            chk("pc", pc_out, sb[0].pc);
        end else begin
            chk("instr_nop", instruction_out, NOP);
            chk("pc_zero", pc_out, 32'h0);
        end
        acc    = !pending && (sb.size() < DEPTH) && rdy;
        do_pop = (sb.size() != 0) && ld && !redir;
        if (acc) begin
            chk("addr", imem_addr, model_pc);
            chk("hi_addr", hi_addr, hi_pc);
        end
        if (redir) begin
            sb.delete();
            if (rv) begin
                pending = 1'b0;
                discard = 1'b0;
            end else if (pending) begin
                discard = 1'b1;
            end
            if (acc) begin
                pending      = 1'b1;
                discard      = 1'b1;
                pending_addr = model_pc;
            end
            model_pc = rpc & ~32'd3;
            hi_pc    = rpc & ~32'd3;
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (rv) begin
                if (!discard) begin
                    e.instr = mem_word(pending_addr);
                    e.pc    = pending_addr;
                    sb.push_back(e);
                end
                pending = 1'b0;
                discard = 1'b0;
            end
            if (acc) begin
                pending      = 1'b1;
                discard      = 1'b0;
                pending_addr = model_pc;
                model_pc     = model_pc + 32'd4;
                hi_pc        = hi_pc + 32'd4;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset(input bit rv_en);
        reset          = 1'b1;
        imem_ready     = 1'b1;
        id_load        = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rvalid    = pending && rv_en;
        imem_rdata     = mem_word(pending_addr);
        @(posedge clock);
        @(negedge clock);
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        model_clear(32'h0, HI_RST);
    endtask

    // Advance with responses held off until a request is outstanding (WAIT state).
    task automatic wait_pending(input string tag);
        int n = 0;
        while (!pending && n < 8) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            n++;
        end
        if (!pending) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no request accepted within 8 cycles (observed req=%b, expected 1)",
                     tag, imem_req);
        end
    endtask

    initial begin
        pending_addr = 32'h0;
        model_clear(32'h0, HI_RST);
        do_reset(1'b0);

        chk("rst_valid", {31'b0, valid_out}, 32'h0);
        chk("rst_instr", instruction_out, NOP);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_hi_addr", hi_addr, HI_RST);

        // Streaming: ready=1, one-cycle response, consumer always loading.
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Consumer stall fills the buffer, then release.
        repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_full_req", {31'b0, imem_req}, 32'h0);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect while waiting for a response; late word must be dropped.
        wait_pending("t3_wait");
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
        chk("t3_valid_after", {31'b0, valid_out}, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t3_next_addr", imem_addr, 32'h0000_0100);
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a response and a consumer load.
        wait_pending("t4_wait");
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("t4_empty", {31'b0, valid_out}, 32'h0);
        chk("t4_next_addr", imem_addr, 32'h0000_0200);
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Address wrap at the top of the space.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Reset landing on a cycle with a response outstanding.
        wait_pending("t6_wait");
        do_reset(1'b1);
        chk("t6_valid", {31'b0, valid_out}, 32'h0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_hi_addr", hi_addr, HI_RST);
        repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
